// File: rtl/up_cpu_bridge_pkg.sv
// Shared definitions for the up-protocol CPU-side master.
package up_cpu_bridge_pkg;

  // Bridge transaction states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STRB,
    ST_WAIT,
    ST_DONE,
    ST_FLUSH
  } up_state_e;

  // uprdy latency of the configuration RAM macro; a late uprdy can
  // arrive up to this many cycles after upen is dropped.
  localparam int unsigned UP_RAM_RDY_LAT = 2;

endpackage

// File: rtl/up_tout_cnt.sv
// Clear/enable timeout counter with a terminal pulse for up-protocol masters.
// limit = 0 disables the terminal pulse; the count saturates instead of wrapping.
module up_tout_cnt #(
  parameter int unsigned G_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic [G_W-1:0] limit,
  output logic           term
);

  logic [G_W-1:0] cnt_q;
  logic [G_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Terminal pulse on the cycle the limit-th enabled cycle is counted.
  always_comb begin
    term = en && !clr && (limit != '0) && (cnt_q == (limit - 1'b1));
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/up_cpu_bridge.sv
// Host-strobe to up-protocol master: one outstanding access, single-cycle
// upws/uprs, held upen/upa/updi, programmable timeout with post-abort flush.
module up_cpu_bridge
  import up_cpu_bridge_pkg::*;
#(
  parameter int unsigned G_ADDR   = 10,
  parameter int unsigned G_WIDTH  = 32,
  parameter int unsigned G_TOUT_W = 8,
  parameter int unsigned G_FLUSH  = UP_RAM_RDY_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hreq,
  input  logic                hwr,
  input  logic [G_ADDR-1:0]   haddr,
  input  logic [G_WIDTH-1:0]  hwdata,
  input  logic [G_TOUT_W-1:0] htout,
  output logic                hbusy,
  output logic                hack,
  output logic                herr,
  output logic [G_WIDTH-1:0]  hrdata,
  output logic                upen,
  output logic [G_ADDR-1:0]   upa,
  output logic                upws,
  output logic                uprs,
  output logic [G_WIDTH-1:0]  updi,
  input  logic [G_WIDTH-1:0]  updo,
  input  logic                uprdy
);

  localparam int unsigned FW = (G_FLUSH > 1) ? $clog2(G_FLUSH) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(G_FLUSH - 1);

  up_state_e             state_q, state_d;
  logic                  dir_q, dir_d;
  logic [G_TOUT_W-1:0]   limit_q, limit_d;
  logic [FW-1:0]         flush_q, flush_d;
  logic                  hbusy_q, hbusy_d;
  logic                  hack_q, hack_d;
  logic                  herr_q, herr_d;
  logic [G_WIDTH-1:0]    hrdata_q, hrdata_d;
  logic                  upen_q, upen_d;
  logic [G_ADDR-1:0]     upa_q, upa_d;
  logic                  upws_q, upws_d;
  logic                  uprs_q, uprs_d;
  logic [G_WIDTH-1:0]    updi_q, updi_d;
  logic                  cnt_clr, cnt_en, cnt_term;

  up_tout_cnt #(
    .G_W (G_TOUT_W)
  ) u_tout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (limit_q),
    .term  (cnt_term)
  );

  // Outputs are registered, so each *_d holds the value for the state being entered.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    limit_d  = limit_q;
    flush_d  = flush_q;
    hbusy_d  = hbusy_q;
    hack_d   = 1'b0;
    herr_d   = 1'b0;
    hrdata_d = hrdata_q;
    upen_d   = upen_q;
    upa_d    = upa_q;
    upws_d   = 1'b0;
    uprs_d   = 1'b0;
    updi_d   = updi_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hreq) begin
          state_d = ST_STRB;
          dir_d   = hwr;
          limit_d = htout;
          upa_d   = haddr;
          updi_d  = hwdata;
          hbusy_d = 1'b1;
          upen_d  = 1'b1;
          upws_d  = hwr;
          uprs_d  = !hwr;
        end
      end

      // STRB shares WAIT's completion path; the counter only runs in WAIT,
      // so STRB itself can never time out.
      ST_STRB, ST_WAIT: begin
        cnt_clr = (state_q == ST_STRB);
        cnt_en  = (state_q == ST_WAIT);
        if (uprdy) begin
          if (!dir_q) begin
            hrdata_d = updo;
          end
          upen_d  = 1'b0;
          hack_d  = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_term) begin
          upen_d  = 1'b0;
          flush_d = '0;
          state_d = ST_FLUSH;
          if (FLUSH_LAST == '0) begin
            hack_d = 1'b1;
            herr_d = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        hbusy_d = 1'b0;
        state_d = ST_IDLE;
      end

      ST_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          hbusy_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          flush_d = flush_q + 1'b1;
          if ((flush_q + 1'b1) == FLUSH_LAST) begin
            hack_d = 1'b1;
            herr_d = 1'b1;
          end
        end
      end

      default: begin
        hbusy_d = 1'b0;
        upen_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, all async-cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      limit_q  <= '0;
      flush_q  <= '0;
      hbusy_q  <= 1'b0;
      hack_q   <= 1'b0;
      herr_q   <= 1'b0;
      hrdata_q <= '0;
      upen_q   <= 1'b0;
      upa_q    <= '0;
      upws_q   <= 1'b0;
      uprs_q   <= 1'b0;
      updi_q   <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      limit_q  <= limit_d;
      flush_q  <= flush_d;
      hbusy_q  <= hbusy_d;
      hack_q   <= hack_d;
      herr_q   <= herr_d;
      hrdata_q <= hrdata_d;
      upen_q   <= upen_d;
      upa_q    <= upa_d;
      upws_q   <= upws_d;
      uprs_q   <= uprs_d;
      updi_q   <= updi_d;
    end
  end

  assign hbusy  = hbusy_q;
  assign hack   = hack_q;
  assign herr   = herr_q;
  assign hrdata = hrdata_q;
  assign upen   = upen_q;
  assign upa    = upa_q;
  assign upws   = upws_q;
  assign uprs   = uprs_q;
  assign updi   = updi_q;

endmodule

// File: tb/tb_up_cpu_bridge.sv
// Self-checking bench for up_cpu_bridge: directed cases plus randomized
// transactions judged by a per-transaction outcome model.
module tb_up_cpu_bridge;

  localparam int unsigned TB_FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hreq = 1'b0;
  logic        hwr = 1'b0;
  logic [9:0]  haddr = '0;
  logic [31:0] hwdata = '0;
  logic [7:0]  htout = '0;
  logic        hbusy, hack, herr;
  logic [31:0] hrdata;
  logic        upen, upws, uprs;
  logic [9:0]  upa;
  logic [31:0] updi;
  logic [31:0] updo = '0;
  logic        uprdy = 1'b0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_hrdata = '0;

  up_cpu_bridge #(
    .G_ADDR   (10),
    .G_WIDTH  (32),
    .G_TOUT_W (8),
    .G_FLUSH  (TB_FLUSH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .hreq   (hreq),
    .hwr    (hwr),
    .haddr  (haddr),
    .hwdata (hwdata),
    .htout  (htout),
    .hbusy  (hbusy),
    .hack   (hack),
    .herr   (herr),
    .hrdata (hrdata),
    .upen   (upen),
    .upa    (upa),
    .upws   (upws),
    .uprs   (uprs),
    .updi   (updi),
    .updo   (updo),
    .uprdy  (uprdy)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One host transaction. d = cycles after the strobe cycle at which uprdy
  // pulses (0 = never). Called and returns at a falling edge with the DUT idle.
  task automatic txn(input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                     input logic [7:0] lim, input int unsigned d, input logic [31:0] rd,
                     input bit late, input bit poke);
    bit          ok, stable;
    int unsigned limi, exp_hack, exp_upen, bound, c;
    int unsigned upen_n, strb_n, hack_n;
    logic [31:0] hack_at;
    logic        herr_at, upen_at_hack;

    limi     = int'(lim);
    ok       = (d != 0) && ((limi == 0) || (d <= limi));
    exp_hack = ok ? d + 1 : limi + TB_FLUSH;
    exp_upen = ok ? d + 1 : limi + 1;
    bound    = exp_hack + 6;
    upen_n = 0; strb_n = 0; hack_n = 0;
    hack_at = '1; herr_at = 1'bx; upen_at_hack = 1'bx; stable = 1'b1;

    chk1("idle_before_req", hbusy, 1'b0);
    hreq = 1'b1; hwr = wr; haddr = addr; hwdata = wd; htout = lim;
    @(negedge clk);
    hreq = 1'b0; hwr = 1'($urandom); haddr = 10'($urandom);
    hwdata = $urandom; htout = 8'($urandom);

    chk1("strb_upen", upen, 1'b1);
    chk1("strb_upws", upws, wr);
    chk1("strb_uprs", uprs, !wr);
    chk32("strb_upa", 32'(upa), 32'(addr));
    chk32("strb_updi", updi, wd);
    chk1("strb_hbusy", hbusy, 1'b1);

    c = 0;
    while (hack_n == 0 && c < bound) begin
      if (upen) upen_n++;
      if (upws || uprs) strb_n++;
      if (upen && ((upa !== addr) || (updi !== wd))) stable = 1'b0;
      if (hack) begin
        hack_n++;
        hack_at = c;
        herr_at = herr;
        upen_at_hack = upen;
      end
      uprdy = ((d != 0) && (c == d)) || (late && !ok && (c == limi + 1));
      updo  = ((d != 0) && (c == d)) ? rd : $urandom;
      hreq  = poke && (c == 1);
      haddr = 10'($urandom);
      @(negedge clk);
      c++;
    end
    uprdy = 1'b0;
    hreq  = 1'b0;

    if (ok && !wr) exp_hrdata = rd;
    chk32("hack_cycle", hack_at, exp_hack);
    chk1("herr", herr_at, !ok);
    chk1("upen_low_at_hack", upen_at_hack, 1'b0);
    chk32("upen_cycles", upen_n, exp_upen);
    chk32("strobe_count", strb_n, 32'd1);
    chk1("upa_updi_stable", stable, 1'b1);
    chk32("hrdata", hrdata, exp_hrdata);
    chk1("hack_single", hack, 1'b0);
    chk1("hbusy_after", hbusy, 1'b0);
    chk1("upen_after", upen, 1'b0);
    chk1("strobes_after", upws | uprs, 1'b0);
  endtask

  initial begin
    int unsigned d;
    logic [7:0]  lim;

    repeat (3) @(negedge clk);
    chk1("rst_hbusy", hbusy, 1'b0);
    chk1("rst_hack", hack, 1'b0);
    chk1("rst_herr", herr, 1'b0);
    chk32("rst_hrdata", hrdata, 32'd0);
    chk1("rst_upen", upen, 1'b0);
    chk1("rst_upws", upws, 1'b0);
    chk1("rst_uprs", uprs, 1'b0);
    chk32("rst_upa", 32'(upa), 32'd0);
    chk32("rst_updi", updi, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain read, uprdy two cycles after the strobe.
    txn(1'b0, 10'h005, $urandom, 8'd16, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    // Write held through a long engine stall.
    txn(1'b1, 10'h3FF, 32'h12345678, 8'd16, 9, $urandom, 1'b0, 1'b0);
    // Timeout after 4 WAIT cycles, late uprdy in the first flush cycle.
    txn(1'b0, 10'h111, $urandom, 8'd4, 0, $urandom, 1'b1, 1'b0);
    // uprdy coincides with the terminal count: success.
    txn(1'b0, 10'h0A5, $urandom, 8'd5, 5, 32'hCAFEF00D, 1'b0, 1'b0);
    // Timeout disabled, uprdy long past the counter range.
    txn(1'b0, 10'h2C3, $urandom, 8'd0, 300, 32'h0BADF00D, 1'b0, 1'b0);
    // hreq pulse while busy must be dropped.
    txn(1'b1, 10'h155, $urandom, 8'd8, 3, $urandom, 1'b0, 1'b1);
    txn(1'b0, 10'h001, $urandom, 8'd1, 1, 32'h5A5A0001, 1'b0, 1'b1);

    // Reset in the middle of WAIT.
    hreq = 1'b1; hwr = 1'b0; haddr = 10'h02A; htout = 8'd20;
    @(negedge clk);
    hreq = 1'b0;
    repeat (3) @(negedge clk);
    chk1("prerst_upen", upen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_upen", upen, 1'b0);
    chk1("midrst_hbusy", hbusy, 1'b0);
    uprdy = 1'b1;
    updo  = 32'hFFFF0000;
    repeat (3) begin
      @(negedge clk);
      chk1("midrst_no_hack", hack, 1'b0);
    end
    uprdy = 1'b0;
    rst_n = 1'b1;
    exp_hrdata = '0;
    @(negedge clk);
    chk1("postrst_hbusy", hbusy, 1'b0);
    chk1("postrst_upen", upen, 1'b0);
    chk1("postrst_hack", hack, 1'b0);
    chk32("postrst_hrdata", hrdata, exp_hrdata);

    // Randomized transactions, issued back-to-back.
    for (int i = 0; i < 30; i++) begin
      lim = 8'($urandom_range(0, 10));
      d   = $urandom_range(0, 14);
      if (lim == 8'd0 && d == 0) d = 5;
      txn(1'($urandom), 10'($urandom), $urandom, lim, d, $urandom,
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/up_cpu_bridge.md
Name: up_cpu_bridge

Overview:
- Upstream CPU-side master for the up-protocol configuration RAM macros (2-read/0-write engine RAM with CPU arbitration).
- Converts a simple single-request host strobe into a held up-protocol transaction: upen, single-cycle upws/uprs strobe, address/data held stable.
- Waits for uprdy, returns read data, and aborts with an error after a programmable timeout, since the engine can starve the CPU indefinitely.
- Guarantees the one-outstanding, strobe-once, upen-drop-on-timeout rules the RAM macro relies on.

Parameters:
- G_ADDR, 10, address width of upa/haddr.
- G_WIDTH, 32, data width.
- G_TOUT_W, 8, width of the timeout counter.
- G_FLUSH, 2, cycles ignored after an abort; equals the RAM macro's uprdy latency.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- hreq  in  1  host request pulse; sampled only when hbusy=0.
- hwr  in  1  1=write, 0=read; sampled with hreq.
- haddr  in  G_ADDR  host address; sampled with hreq.
- hwdata  in  G_WIDTH  host write data; sampled with hreq.
- htout  in  G_TOUT_W  timeout limit in cycles; sampled with hreq. 0 disables the timeout.
- hbusy  out  1  bridge not in IDLE.
- hack  out  1  one-cycle completion pulse, for both success and error.
- herr  out  1  valid with hack: 1=timeout abort.
- hrdata  out  G_WIDTH  read data; valid from hack and held until the next read completes.
- upen  out  1  up-protocol enable.
- upa  out  G_ADDR  up address.
- upws  out  1  write strobe.
- uprs  out  1  read strobe.
- updi  out  G_WIDTH  write data.
- updo  in  G_WIDTH  read data from the RAM macro.
- uprdy  in  1  access-complete from the RAM macro.

Behaviour:
- Reset:
  - All outputs are registered and async-cleared to 0.
  - State goes to IDLE; counter goes to 0.
  - Reset mid-transaction drops upen immediately and emits no hack.
- FSM states: IDLE, STRB, WAIT, DONE, FLUSH.
- IDLE:
  - hbusy=0.
  - On hreq, capture haddr/hwdata/hwr/htout into upa/updi/dir/limit and go to STRB.
  - hreq in any other state is ignored and not queued.
- STRB:
  - Exactly one cycle: upen=1, with upws=hwr or uprs=!hwr.
  - Counter is cleared.
  - Go to WAIT.
  - uprdy sampled in STRB is impossible; treat it as WAIT would.
- WAIT:
  - upen=1, upws=uprs=0; upa/updi held constant. Counter increments per cycle.
  - If uprdy=1: capture updo into hrdata (reads only; hrdata unchanged on writes), drop upen, go to DONE.
  - Else if limit≠0 and counter==limit-1: drop upen, go to FLUSH. Timeout occurs after exactly `limit` WAIT cycles.
  - If uprdy and the timeout coincide in the same cycle, uprdy wins (success).
- DONE:
  - hack=1, herr=0 for one cycle; upen=0.
  - Go to IDLE. This guarantees upen is low for ≥1 cycle between transactions.
- FLUSH:
  - upen=0 for G_FLUSH cycles.
  - uprdy is ignored and hrdata is unchanged, absorbing a late uprdy from an access granted on the last WAIT cycle.
  - On the last FLUSH cycle: hack=1, herr=1, then go to IDLE.
- Latency with no engine contention (macro grants combinationally):
  - hreq at T0.
  - upen/strobe at T1.
  - uprdy at T3.
  - hack at T4.
  - hbusy high T1..T4.
  - Next hreq is accepted at T5 at the earliest.
- Counter arithmetic: G_TOUT_W unsigned; saturates (never wraps) when limit=0.
- Strobes are never asserted outside STRB, because the RAM macro re-issues accesses while a strobe is held.

Decomposition:
- Shared package: FSM state encoding constants (IDLE/STRB/WAIT/DONE/FLUSH) and the default G_FLUSH=2 tied to the RAM macro's read latency.
- Optional sub-module up_tout_cnt: clear/enable/limit counter with a terminal pulse, also reusable by other up masters.
- Pipeline flops use the codebase's standard s_dff / s_pl_reg primitives.

Test Plan:
- Read, no contention:
  - Stimulus: hreq, hwr=0, haddr=0x05, htout=16; model returns updo=0xDEADBEEF with uprdy 2 cycles after the strobe.
  - Required: uprs high exactly at T1, hack at T4, herr=0, hrdata=0xDEADBEEF.
- Write with engine stall:
  - Stimulus: hwr=1, haddr=0x3FF, hwdata=0x12345678; model delays uprdy 9 cycles.
  - Required: upws high one cycle only; upa/updi stable through WAIT; hack=1/herr=0 one cycle after uprdy; hrdata unchanged.
- Timeout:
  - Stimulus: htout=4, no uprdy.
  - Required: upen high 5 cycles (STRB + 4 WAIT); hack+herr exactly 2 cycles after upen falls.
  - Then, after the request has timed out: a uprdy injected in the first FLUSH cycle is ignored and hrdata is unchanged.
- Boundary conditions:
  - uprdy on the same cycle as counter==limit-1 → success (herr=0).
  - htout=0 with uprdy after 300 cycles → success, no wrap-induced abort.
- Protocol:
  - hreq pulses while hbusy=1 → ignored, no second strobe.
  - Back-to-back requests → upen low ≥1 cycle between transactions.
  - rst_n asserted during WAIT → upen=0 asynchronously, no hack, IDLE after release.
